// File: rtl/rshift_rx_pkg.sv
// rshift_rx_pkg: shared types for the right-shift serial receiver.
// FSM state encoding and serial line levels.
package rshift_rx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PAR,
      STOP
   } state_t;

   localparam logic LVL_IDLE  = 1'b1;
   localparam logic LVL_START = 1'b0;
   localparam logic LVL_STOP  = 1'b1;

endpackage

// File: rtl/rshift_rx_ctrl_core.sv
// rshift_core: WIDTH-bit right-shift register, MSB entry.
// Synchronous clear has priority over shift.
module rshift_core
   import rshift_rx_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             shift_en,
   input  logic             sin,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (clr)
         q <= '0;
      else if (shift_en)
         q <= {sin, q[WIDTH-1:1]};
   end

endmodule

// File: rtl/rshift_rx_ctrl.sv
// rshift_rx_ctrl: LSB-first serial receiver with valid/ready output.
// Optional parity stage enabled by RSHIFT_RX_PARITY_EN.
module rshift_rx_ctrl
   import rshift_rx_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int DIV   = 4
) (
   input  logic             clk,
   input  logic             clrb,
   input  logic             en,
   input  logic             sdi,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             frame_err,
   output logic             overrun,
   input  logic             overrun_clr,
   output logic             busy
);

   localparam int DW = $clog2(DIV);
   localparam int BW = $clog2(WIDTH);
   localparam logic [DW-1:0] DLAST = DW'(DIV - 1);
   localparam logic [DW-1:0] DHALF = DW'(DIV / 2 - 1);
   localparam logic [BW-1:0] BLAST = BW'(WIDTH - 1);

   state_t           state;
   logic [DW-1:0]    divcnt;
   logic [BW-1:0]    bitcnt;
   logic [WIDTH-1:0] shreg;
   logic             tick;
   logic             shift;
   logic             parerr;
   logic             stop_ok;
   logic             take;

   assign tick    = (divcnt == DLAST);
   assign shift   = (state == DATA) && tick;
   assign stop_ok = (sdi == LVL_STOP) && !parerr;
   // a finished word may land if the slot is empty or drains this cycle
   assign take    = !out_valid || out_ready;

   rshift_core #(
      .WIDTH(WIDTH)
   ) u_core (
      .clk     (clk),
      .clr     (!clrb),
      .shift_en(shift),
      .sin     (sdi),
      .q       (shreg)
   );

`ifdef RSHIFT_RX_PARITY_EN
   always_ff @(posedge clk) begin
      if (!clrb)
         parerr <= 1'b0;
      else if (state == IDLE)
         parerr <= 1'b0;
      else if (state == PAR && tick)
         parerr <= ^{shreg, sdi};
   end
`else
   assign parerr = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!clrb) begin
         state     <= IDLE;
         divcnt    <= '0;
         bitcnt    <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         busy      <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         if (out_valid && out_ready)
            out_valid <= 1'b0;
         if (overrun_clr)
            overrun <= 1'b0;
         case (state)
            IDLE: begin
               if (en && sdi == LVL_START) begin
                  state  <= START;
                  divcnt <= '0;
                  busy   <= 1'b1;
               end
            end
            START: begin
               if (divcnt == DHALF) begin
                  divcnt <= '0;
                  bitcnt <= '0;
                  if (sdi == LVL_IDLE) begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end else begin
                     state <= DATA;
                  end
               end else begin
                  divcnt <= divcnt + 1'b1;
               end
            end
            DATA: begin
               if (tick) begin
                  divcnt <= '0;
                  if (bitcnt == BLAST) begin
`ifdef RSHIFT_RX_PARITY_EN
                     state <= PAR;
`else
                     state <= STOP;
`endif
                  end else begin
                     bitcnt <= bitcnt + 1'b1;
                  end
               end else begin
                  divcnt <= divcnt + 1'b1;
               end
            end
`ifdef RSHIFT_RX_PARITY_EN
            PAR: begin
               if (tick) begin
                  divcnt <= '0;
                  state  <= STOP;
               end else begin
                  divcnt <= divcnt + 1'b1;
               end
            end
`endif
            STOP: begin
               if (tick) begin
                  divcnt <= '0;
                  state  <= IDLE;
                  busy   <= 1'b0;
                  if (stop_ok) begin
                     if (take) begin
                        out_data  <= shreg;
                        out_valid <= 1'b1;
                     end else begin
                        overrun <= 1'b1;
                     end
                  end else begin
                     frame_err <= 1'b1;
                  end
               end else begin
                  divcnt <= divcnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rshift_rx_ctrl.sv
// tb_rshift_rx_ctrl: directed frames against a frame-level event model.
// Build with RSHIFT_RX_PARITY_EN to exercise the parity stage.
module tb_rshift_rx_ctrl;

   localparam int WIDTH = 4;
   localparam int DIV   = 4;
`ifdef RSHIFT_RX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif

   logic             clk = 1'b0;
   logic             clrb = 1'b0;
   logic             en = 1'b0;
   logic             sdi = 1'b1;
   logic             out_ready = 1'b0;
   logic             overrun_clr = 1'b0;
   logic [WIDTH-1:0] out_data;
   logic             out_valid;
   logic             frame_err;
   logic             overrun;
   logic             busy;

   always #5 clk = ~clk;

   rshift_rx_ctrl #(
      .WIDTH(WIDTH),
      .DIV  (DIV)
   ) dut (
      .clk        (clk),
      .clrb       (clrb),
      .en         (en),
      .sdi        (sdi),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .overrun_clr(overrun_clr),
      .busy       (busy)
   );

   int tests = 0;
   int failed = 0;
   int ecount = 0;
   int ferr_cnt = 0;

   always @(posedge clk) ecount <= ecount + 1;
   always @(negedge clk) if (frame_err === 1'b1) ferr_cnt++;

   // kind: 0 = no output (false start / aborted), 1 = word, 2 = frame error
   typedef struct {
      int               lo;
      int               at;
      int               kind;
      logic [WIDTH-1:0] w;
   } ev_t;

   ev_t evq[$];

   logic [WIDTH-1:0] m_data = '0;
   bit m_valid = 0;
   bit m_ovr = 0;
   bit m_ferr = 0;
   bit r_rdy = 0;
   bit r_oc = 0;
   bit r_rb = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h at edge %0d",
                  nm, act, exp, ecount);
      end
   endtask

   always @(negedge clk) begin : model_cmp
      bit prev;
      bit set;
      bit m_busy;
      prev   = m_valid;
      set    = 0;
      m_ferr = 0;
      if (!r_rb) begin
         m_data  = '0;
         m_valid = 0;
         m_ovr   = 0;
         evq.delete();
      end else begin
         if (m_valid && r_rdy) m_valid = 0;
         foreach (evq[i]) begin
            if (evq[i].at == ecount) begin
               if (evq[i].kind == 1) begin
                  if (prev && !r_rdy) set = 1;
                  else begin
                     m_data  = evq[i].w;
                     m_valid = 1;
                  end
               end else if (evq[i].kind == 2) begin
                  m_ferr = 1;
               end
            end
         end
         if (set) m_ovr = 1;
         else if (r_oc) m_ovr = 0;
      end
      m_busy = 0;
      foreach (evq[i])
         if (evq[i].lo <= ecount && ecount < evq[i].at) m_busy = 1;
      chk("out_data", 32'(out_data), 32'(m_data));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("frame_err", 32'(frame_err), 32'(m_ferr));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      chk("busy", 32'(busy), 32'(m_busy));
      r_rdy = out_ready;
      r_oc  = overrun_clr;
      r_rb  = clrb;
   end

   task automatic tick1();
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [WIDTH-1:0] w, input logic stopb,
                             input logic parb, input bit rdy_pulse);
      int det;
      int at;
      bit good;
      det  = ecount + 1;
      at   = det + DIV / 2 + WIDTH * DIV + PB * DIV + DIV;
      good = stopb && (PB == 0 || (^{w, parb}) == 1'b0);
      evq.push_back('{det, at, good ? 1 : 2, w});
      // a low stop bit is seen as a new start once back in IDLE
      if (!stopb) evq.push_back('{at + 1, at + 1 + DIV / 2, 0, '0});
      sdi = 1'b0;
      repeat (DIV) tick1();
      for (int i = 0; i < WIDTH; i++) begin
         sdi = w[i];
         repeat (DIV) tick1();
      end
      if (PB != 0) begin
         sdi = parb;
         repeat (DIV) tick1();
      end
      sdi = stopb;
      repeat (DIV - 2) tick1();
      if (rdy_pulse) out_ready = 1'b1;
      tick1();
      if (rdy_pulse) out_ready = 1'b0;
      tick1();
      sdi = 1'b1;
   endtask

   task automatic consume();
      out_ready = 1'b1;
      tick1();
      out_ready = 1'b0;
      tick1();
   endtask

   initial begin
      int det;
      int fc;
      repeat (3) tick1();
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_data", 32'(out_data), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ovr", 32'(overrun), 0);
      chk("rst_ferr", 32'(frame_err), 0);
      clrb = 1'b1;
      en   = 1'b1;
      repeat (2) tick1();

      send_frame(4'hA, 1'b1, ^4'hA, 0);
      chk("a_valid", 32'(out_valid), 1);
      chk("a_data", 32'(out_data), 32'hA);
      chk("a_ferr", 32'(frame_err), 0);
      out_ready = 1'b1;
      tick1();
      out_ready = 1'b0;
      chk("a_drop", 32'(out_valid), 0);
      repeat (2) tick1();

      det = ecount + 1;
      evq.push_back('{det, det + DIV / 2, 0, '0});
      sdi = 1'b0;
      tick1();
      sdi = 1'b1;
      chk("fs_busy", 32'(busy), 1);
      repeat (6) tick1();
      chk("fs_valid", 32'(out_valid), 0);
      chk("fs_idle", 32'(busy), 0);

      fc = ferr_cnt;
      send_frame(4'h5, 1'b0, ^4'h5, 0);
      repeat (6) tick1();
      chk("bs_pulses", 32'(ferr_cnt - fc), 1);
      chk("bs_valid", 32'(out_valid), 0);
      chk("bs_data", 32'(out_data), 32'hA);

      send_frame(4'h3, 1'b1, ^4'h3, 0);
      send_frame(4'hC, 1'b1, ^4'hC, 0);
      chk("ov_data", 32'(out_data), 32'h3);
      chk("ov_flag", 32'(overrun), 1);
      chk("ov_valid", 32'(out_valid), 1);
      overrun_clr = 1'b1;
      tick1();
      overrun_clr = 1'b0;
      chk("ov_clr", 32'(overrun), 0);
      repeat (2) tick1();

      send_frame(4'hC, 1'b1, ^4'hC, 1);
      chk("sim_data", 32'(out_data), 32'hC);
      chk("sim_valid", 32'(out_valid), 1);
      chk("sim_ovr", 32'(overrun), 0);
      repeat (2) tick1();

      det = ecount + 1;
      evq.push_back('{det, 1 << 30, 0, '0});
      sdi = 1'b0;
      repeat (DIV) tick1();
      sdi = 1'b1;
      repeat (DIV) tick1();
      sdi = 1'b0;
      repeat (DIV) tick1();
      chk("mr_busy", 32'(busy), 1);
      clrb = 1'b0;
      sdi  = 1'b1;
      tick1();
      chk("mr_valid", 32'(out_valid), 0);
      chk("mr_data", 32'(out_data), 0);
      chk("mr_busy0", 32'(busy), 0);
      chk("mr_ovr", 32'(overrun), 0);
      chk("mr_ferr", 32'(frame_err), 0);
      clrb = 1'b1;
      repeat (3) tick1();
      send_frame(4'h9, 1'b1, ^4'h9, 0);
      chk("r9_valid", 32'(out_valid), 1);
      chk("r9_data", 32'(out_data), 32'h9);
      consume();

`ifdef RSHIFT_RX_PARITY_EN
      send_frame(4'h7, 1'b1, 1'b1, 0);
      chk("p_ok_valid", 32'(out_valid), 1);
      chk("p_ok_data", 32'(out_data), 32'h7);
      consume();
      fc = ferr_cnt;
      send_frame(4'h7, 1'b1, 1'b0, 0);
      tick1();
      chk("p_bad_valid", 32'(out_valid), 0);
      chk("p_bad_pulse", 32'(ferr_cnt - fc), 1);
`endif

      repeat (4) tick1();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
